// File: rtl/loss_accum_pkg.sv
// Shared training-pipeline constants and the loss accumulator state encoding.
package loss_accum_pkg;

  localparam int LOSS_W_DEF     = 42;
  localparam int BATCH_LOG2_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/loss_accum_if.sv
// Sample/result bundle between the loss stage, loss_accum and the training controller.
// Optional max_o signal is present only when LOSS_ACCUM_MAX_EN is defined.
interface loss_accum_if
  import loss_accum_pkg::*;
#(
  parameter int LOSS_W     = LOSS_W_DEF,
  parameter int BATCH_LOG2 = BATCH_LOG2_DEF
);
  localparam int ACC_W = LOSS_W + BATCH_LOG2;

  logic                  start_i;
  logic                  loss_valid_i;
  logic [LOSS_W-1:0]     loss_i;
  logic                  busy_o;
  logic [BATCH_LOG2:0]   cnt_o;
  logic [ACC_W-1:0]      sum_o;
  logic [LOSS_W-1:0]     mean_o;
  logic                  done_o;
`ifdef LOSS_ACCUM_MAX_EN
  logic [LOSS_W-1:0]     max_o;

  modport master (output start_i, loss_valid_i, loss_i,
                  input  busy_o, cnt_o, sum_o, mean_o, done_o, max_o);
  modport slave  (input  start_i, loss_valid_i, loss_i,
                  output busy_o, cnt_o, sum_o, mean_o, done_o, max_o);
`else
  modport master (output start_i, loss_valid_i, loss_i,
                  input  busy_o, cnt_o, sum_o, mean_o, done_o);
  modport slave  (input  start_i, loss_valid_i, loss_i,
                  output busy_o, cnt_o, sum_o, mean_o, done_o);
`endif

endinterface

// File: rtl/loss_accum.sv
// Accumulates a batch of 2^BATCH_LOG2 loss samples and reports sum, truncated mean and a done pulse.
// Define LOSS_ACCUM_MAX_EN to also report the largest sample of the batch on max_o.
module loss_accum
  import loss_accum_pkg::*;
#(
  parameter int LOSS_W     = LOSS_W_DEF,
  parameter int BATCH_LOG2 = BATCH_LOG2_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  loss_accum_if.slave  bus
);

  localparam int ACC_W = LOSS_W + BATCH_LOG2;
  localparam int CNT_W = BATCH_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << BATCH_LOG2) - 1);

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LOSS_W-1:0]   mean_q, mean_d;
  logic                done_q, done_d;
  logic                accept;
  logic                clear;

  // start wins over a same-cycle sample; samples only count while accumulating
  assign clear  = bus.start_i && (state_q == IDLE || state_q == ACCUM);
  assign accept = (state_q == ACCUM) && !bus.start_i && bus.loss_valid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_i) state_d = ACCUM;
      ACCUM:   if (accept && cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    mean_d = mean_q;
    done_d = 1'b0;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = acc_q + {{BATCH_LOG2{1'b0}}, bus.loss_i};
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == DONE) begin
      sum_d  = acc_q;
      mean_d = acc_q[ACC_W-1:BATCH_LOG2];
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      mean_q <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      mean_q <= mean_d;
      done_q <= done_d;
    end
  end

  assign bus.busy_o = (state_q == ACCUM) || (state_q == DONE);
  assign bus.cnt_o  = cnt_q;
  assign bus.sum_o  = sum_q;
  assign bus.mean_o = mean_q;
  assign bus.done_o = done_q;

`ifdef LOSS_ACCUM_MAX_EN
  logic [LOSS_W-1:0] run_max_q, run_max_d;
  logic [LOSS_W-1:0] max_q, max_d;

  always_comb begin
    run_max_d = run_max_q;
    max_d     = max_q;
    if (clear)
      run_max_d = '0;
    else if (accept && bus.loss_i > run_max_q)
      run_max_d = bus.loss_i;
    if (state_q == DONE)
      max_d = run_max_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run_max_q <= '0;
      max_q     <= '0;
    end else begin
      run_max_q <= run_max_d;
      max_q     <= max_d;
    end
  end

  assign bus.max_o = max_q;
`endif

endmodule

// File: tb/tb_loss_accum.sv
// Randomized bench for loss_accum: a sample-queue model predicts every output each cycle.
`timescale 1ns/1ps
module tb_loss_accum;
  import loss_accum_pkg::*;

  localparam int LW = LOSS_W_DEF;
  localparam int B  = BATCH_LOG2_DEF;
  localparam int N  = 1 << B;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  loss_accum_if #(.LOSS_W(LW), .BATCH_LOG2(B)) bus ();

  loss_accum #(.LOSS_W(LW), .BATCH_LOG2(B)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] q[$];
  bit          collecting, report, m_done;
  logic [63:0] m_sum, m_mean, m_max;

  function automatic logic [63:0] qsum();
    logic [63:0] s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic logic [63:0] qmax();
    logic [63:0] m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  always begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      collecting = 0; report = 0; m_done = 0;
      m_sum = 0; m_mean = 0; m_max = 0;
    end else begin
      m_done = 0;
      if (report) begin
        m_sum  = qsum();
        m_mean = m_sum >> B;
        m_max  = qmax();
        m_done = 1;
        report = 0;
      end else if (collecting) begin
        if (bus.start_i) q.delete();
        else if (bus.loss_valid_i) begin
          q.push_back(64'(bus.loss_i));
          if (q.size() == N) begin
            collecting = 0;
            report     = 1;
          end
        end
      end else if (bus.start_i) begin
        q.delete();
        collecting = 1;
      end
    end
    #1;
    chk("busy", bus.busy_o, collecting || report);
    chk("cnt",  bus.cnt_o, q.size());
    chk("sum",  bus.sum_o, m_sum);
    chk("mean", bus.mean_o, m_mean);
    chk("done", bus.done_o, m_done);
`ifdef LOSS_ACCUM_MAX_EN
    chk("max",  bus.max_o, m_max);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit s, input bit v, input logic [63:0] l);
    @(negedge clk);
    bus.start_i      = s;
    bus.loss_valid_i = v;
    bus.loss_i       = l[LW-1:0];
  endtask

  function automatic logic [63:0] rnd_loss();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r & ((64'd1 << LW) - 1);
  endfunction

  task automatic feed(input logic [63:0] v, input int maxgap);
    repeat ($urandom_range(maxgap, 0)) cyc(0, 0, rnd_loss());
    cyc(0, 1, v);
  endtask

  task automatic start_batch();
    cyc(1, 1'($urandom_range(1, 0)), rnd_loss());
  endtask

  // DONE cycle gets random start/valid, which must be ignored
  task automatic wait_done(input bit lit, input logic [63:0] es, input logic [63:0] em,
                           input string nm);
    int n = 0;
    cyc(1'($urandom_range(1, 0)), 1, rnd_loss());
    do begin
      @(posedge clk); #2;
      n++;
    end while (!bus.done_o && n < 40);
    chk({nm, "_done_seen"}, bus.done_o, 1);
    chk({nm, "_latency"}, n, 1);
    if (lit) begin
      chk({nm, "_sum"}, bus.sum_o, es);
      chk({nm, "_mean"}, bus.mean_o, em);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  logic [63:0] full;
  initial begin
    full = (64'd1 << LW) - 1;
    bus.start_i = 0; bus.loss_valid_i = 0; bus.loss_i = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_cnt",  bus.cnt_o, 0);
    chk("rst_sum",  bus.sum_o, 0);
    chk("rst_done", bus.done_o, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1..8 back to back
    start_batch();
    for (int i = 1; i <= N; i++) feed(i, 0);
    wait_done(1, 36, 4, "seq");

    // 10..80 with gaps
    start_batch();
    for (int i = 1; i <= N; i++) feed(10 * i, 3);
    wait_done(1, 360, 45, "gaps");

    // full-scale samples
    start_batch();
    for (int i = 0; i < N; i++) feed(full, 1);
    wait_done(1, full * 8, full, "full");

    // restart discards partial batch
    start_batch();
    for (int i = 0; i < 3; i++) feed(100, 1);
    cyc(1, 1, 100);
    for (int i = 0; i < N; i++) feed(5, 2);
    wait_done(1, 40, 5, "restart");

    // reset mid-batch
    start_batch();
    for (int i = 0; i < 5; i++) feed(i + 11, 1);
    @(negedge clk);
    rst_n = 1'b0; bus.start_i = 0; bus.loss_valid_i = 0;
    #1;
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_cnt",  bus.cnt_o, 0);
    chk("mid_rst_sum",  bus.sum_o, 0);
    chk("mid_rst_mean", bus.mean_o, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) feed(7, 2);
    cyc(0, 0, 0);
    @(posedge clk); #2;
    chk("idle_valid_cnt",  bus.cnt_o, 0);
    chk("idle_valid_busy", bus.busy_o, 0);
    chk("idle_no_done",    bus.done_o, 0);

`ifdef LOSS_ACCUM_MAX_EN
    begin
      int vals[8] = '{3, 9, 1, 7, 2, 9, 0, 4};
      start_batch();
      foreach (vals[i]) feed(vals[i], 1);
      wait_done(1, 35, 4, "max");
      chk("max_val", bus.max_o, 9);
    end
`endif

    // random batches; next start lands in the IDLE cycle that carries done
    for (int b = 0; b < 12; b++) begin
      start_batch();
      if ($urandom_range(3, 0) == 0) begin
        repeat ($urandom_range(N - 1, 1)) feed(rnd_loss(), 2);
        cyc(1, 1, rnd_loss());
      end
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(3, 0))
          0:       feed(full, 2);
          1:       feed(0, 2);
          default: feed(rnd_loss(), 2);
        endcase
      end
      wait_done(0, 0, 0, "rand");
    end

    repeat (3) cyc(0, 0, 0);
    @(posedge clk); #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
